div16_seq: RTL

DIV16_SEQ -- requirements
Module: div16_seq

---
 rtl/div16_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/div16_seq.sv
// Sequential 16-bit restoring divider: one quotient bit per clock, 16 iterations.
// Optional DIV16_SIGNED_EN adds a signed_op port for two's-complement operands.
module div16_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    input  logic        flush,
`ifdef DIV16_SIGNED_EN
    input  logic        signed_op,
`endif
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_zero
);
    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e         state_q;
    logic [CW-1:0]  count_q;
    logic [W-1:0]   rem_q, dvd_q, dsr_q;
    logic           neg_q_q, neg_r_q;
    logic           busy_q, done_q, div_zero_q;
    logic [W-1:0]   quotient_q, remainder_q;

    logic           neg_a, neg_b;
    logic [W-1:0]   a_mag, b_mag;
    logic [W:0]     rem_sh, diff;
    logic           borrow;
    logic [W-1:0]   rem_nx, quo_nx;

    // Operand magnitudes and result sign flags captured at start
    always_comb begin
`ifdef DIV16_SIGNED_EN
        neg_a = signed_op & dividend[W-1];
        neg_b = signed_op & divisor[W-1];
`else
        neg_a = 1'b0;
        neg_b = 1'b0;
`endif
        a_mag = neg_a ? W'(W'(0) - dividend) : dividend;
        b_mag = neg_b ? W'(W'(0) - divisor)  : divisor;
    end

    // One restoring step. rem_sh < 2*divisor always, so bit 16 of the 17-bit
    // difference is an exact borrow flag and a wrapped result can never look positive.
    always_comb begin
        rem_sh = {rem_q, dvd_q[W-1]};
        diff   = rem_sh - {1'b0, dsr_q};
        borrow = diff[W];
        rem_nx = borrow ? rem_sh[W-1:0] : diff[W-1:0];
        quo_nx = {dvd_q[W-2:0], ~borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start && (divisor == '0)) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            div_zero_q  <= 1'b1;
                        end else if (start) begin
                            state_q    <= CALC;
                            busy_q     <= 1'b1;
                            count_q    <= '0;
                            rem_q      <= '0;
                            dvd_q      <= a_mag;
                            dsr_q      <= b_mag;
                            neg_q_q    <= neg_a ^ neg_b;
                            neg_r_q    <= neg_a;
                            div_zero_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    CALC: begin
                        rem_q   <= rem_nx;
                        dvd_q   <= quo_nx;
                        count_q <= count_q + CW'(1);
                        if (count_q == CW'(W - 1)) begin
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            quotient_q  <= neg_q_q ? W'(W'(0) - quo_nx) : quo_nx;
                            remainder_q <= neg_r_q ? W'(W'(0) - rem_nx) : rem_nx;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
endmodule
